// File: rtl/param_serialized_reg.sv
// Word-to-subword serializer: loads a P_NBITS word and emits it LSB subword first
// over a val/rdy stream, chaining back-to-back words without a bubble.
module param_serialized_reg #(
    parameter int P_NBITS   = 32,
    parameter int P_SUBWORD = 4,
    localparam int NSUB = P_NBITS / P_SUBWORD,
    localparam int IDXW = (NSUB > 1) ? $clog2(NSUB) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [P_NBITS-1:0]   in_word,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [P_SUBWORD-1:0] out_nibble,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_nxt;
    logic [P_NBITS-1:0] sreg;
    logic [IDXW-1:0]    idx;
    logic               last_beat, in_fire, out_fire;

    assign last_beat = (idx == IDXW'(NSUB - 1));
    assign in_fire   = in_val && in_rdy;
    assign out_fire  = out_val && out_rdy;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_fire) state_nxt = SEND;
            SEND: if (out_fire && last_beat && !in_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs; in_rdy sees out_rdy combinationally so the next word loads on the last beat
    always_comb begin
        out_val  = (state == SEND);
        busy     = (state == SEND);
        in_rdy   = (state == IDLE) || (out_fire && last_beat);
        out_last = out_val && last_beat;
    end

    assign out_nibble = sreg[P_SUBWORD-1:0];
    assign out_idx    = idx;

    // datapath: a load wins over the shift when the last beat and a new word coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            idx  <= '0;
        end else if (in_fire) begin
            sreg <= in_word;
            idx  <= '0;
        end else if (out_fire) begin
            if (last_beat) begin
                sreg <= '0;
                idx  <= '0;
            end else begin
                sreg <= sreg >> P_SUBWORD;
                idx  <= idx + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (P_NBITS % P_SUBWORD == 0)
            else $error("P_NBITS must be a multiple of P_SUBWORD");
    end

endmodule

// File: tb/tb_param_serialized_reg.sv
// Directed bench for param_serialized_reg: reset, streaming, backpressure,
// back-to-back, mid-word reset and a loopback through a nibble deserializer model.
module tb_param_serialized_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_word;
    logic        out_val;
    logic        out_rdy;
    logic [3:0]  out_nibble;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] deser;

    param_serialized_reg #(.P_NBITS(32), .P_SUBWORD(4)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_word(in_word),
        .out_val(out_val), .out_rdy(out_rdy), .out_nibble(out_nibble),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // receiving deserializer: subword_en_idx <- out_idx, data_in <- out_nibble
    always @(posedge clk) begin
        if (out_val && out_rdy) deser[out_idx*4 +: 4] <= out_nibble;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_val = 1'b0; in_word = '0; out_rdy = 1'b0;
        tick(); tick();
        checks++;
        if ({out_val, out_nibble, out_idx, out_last, busy, in_rdy} !== {1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: val=%b nib=%h idx=%0d last=%b busy=%b in_rdy=%b, want 0 0 0 0 0 1",
                     out_val, out_nibble, out_idx, out_last, busy, in_rdy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] exp_n [8];
        exp_n = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
        in_val = 1'b1; in_word = 32'h89ABCDEF; out_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL single_in_rdy: got %b want 1", in_rdy);
        end
        tick();
        in_val = 1'b0; in_word = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({out_val, busy, out_nibble, out_idx, out_last} !== {1'b1, 1'b1, exp_n[i], 3'(i), (i == 7)}) begin
                errors++;
                $display("FAIL single_beat%0d: val=%b busy=%b nib=%h idx=%0d last=%b, want 1 1 %h %0d %b",
                         i, out_val, busy, out_nibble, out_idx, out_last, exp_n[i], i, (i == 7));
            end
            tick();
        end
        checks++;
        if ({out_val, busy, in_rdy, out_last} !== 4'b0010) begin
            errors++;
            $display("FAIL single_idle: val=%b busy=%b in_rdy=%b last=%b, want 0 0 1 0", out_val, busy, in_rdy, out_last);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_n [8];
        int n;
        exp_n = '{4'hC, 4'h3, 4'hD, 4'h2, 4'hE, 4'h1, 4'hF, 4'h0};
        in_val = 1'b1; in_word = 32'h0F1E2D3C; out_rdy = 1'b0;
        tick();
        in_val = 1'b0;
        for (int k = 0; k < 16; k++) begin
            out_rdy = (k % 2 == 0);
            #1;
            n = (k + 1) / 2;
            checks++;
            if (k == 15) begin
                if (out_val !== 1'b0) begin
                    errors++; $display("FAIL bp_end: out_val=%b want 0", out_val);
                end
            end else if ({out_val, out_nibble, out_idx} !== {1'b1, exp_n[n], 3'(n)}) begin
                errors++;
                $display("FAIL bp_cycle%0d: val=%b nib=%h idx=%0d, want 1 %h %0d",
                         k, out_val, out_nibble, out_idx, exp_n[n], n);
            end
            tick();
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_n [16];
        exp_n = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1,
                  4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
        in_val = 1'b1; in_word = 32'h12345678; out_rdy = 1'b1;
        tick();
        in_word = 32'hDEADBEEF;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if ({out_val, out_nibble, out_idx, in_rdy} !== {1'b1, exp_n[k], 3'(k % 8), (k % 8 == 7)}) begin
                errors++;
                $display("FAIL b2b_beat%0d: val=%b nib=%h idx=%0d in_rdy=%b, want 1 %h %0d %b",
                         k, out_val, out_nibble, out_idx, in_rdy, exp_n[k], k % 8, (k % 8 == 7));
            end
            tick();
            if (k == 7) in_val = 1'b0;
        end
        checks++;
        if (out_val !== 1'b0) begin
            errors++; $display("FAIL b2b_end: out_val=%b want 0", out_val);
        end
    endtask

    task automatic test_reset_mid();
        in_val = 1'b1; in_word = 32'hCAFEF00D; out_rdy = 1'b1;
        tick();
        in_val = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({out_val, out_idx, out_nibble} !== {1'b1, 3'd3, 4'hF}) begin
            errors++;
            $display("FAIL mid_pre: val=%b idx=%0d nib=%h, want 1 3 f", out_val, out_idx, out_nibble);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({out_val, in_rdy, out_idx, out_nibble} !== {1'b0, 1'b1, 3'd0, 4'h0}) begin
            errors++;
            $display("FAIL mid_after_reset: val=%b in_rdy=%b idx=%0d nib=%h, want 0 1 0 0",
                     out_val, in_rdy, out_idx, out_nibble);
        end
        in_val = 1'b1; in_word = 32'h00000001;
        tick();
        in_val = 1'b0;
        checks++;
        if ({out_val, out_idx, out_nibble} !== {1'b1, 3'd0, 4'h1}) begin
            errors++;
            $display("FAIL mid_next_beat0: val=%b idx=%0d nib=%h, want 1 0 1", out_val, out_idx, out_nibble);
        end
        tick();
        checks++;
        if ({out_val, out_idx, out_nibble} !== {1'b1, 3'd1, 4'h0}) begin
            errors++;
            $display("FAIL mid_next_beat1: val=%b idx=%0d nib=%h, want 1 1 0", out_val, out_idx, out_nibble);
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL mid_drain: val=%b in_rdy=%b, want 0 1", out_val, in_rdy);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] words [1000];
        int n = 0;
        int m = 0;
        for (int i = 0; i < 1000; i++) words[i] = $urandom;
        out_rdy = 1'b1;
        for (int cyc = 0; cyc < 10000 && m < 1000; cyc++) begin
            in_val  = (n < 1000);
            in_word = (n < 1000) ? words[n] : 32'h0;
            #1;
            if (out_val && out_rdy && out_last) begin
                checks++;
                if ({out_nibble, deser[27:0]} !== words[m]) begin
                    errors++;
                    $display("FAIL loopback_word%0d: got %h want %h", m, {out_nibble, deser[27:0]}, words[m]);
                end
                m++;
            end
            if (in_val && in_rdy) n++;
            tick();
        end
        in_val = 1'b0;
        checks++;
        if (m != 1000) begin
            errors++; $display("FAIL loopback_timeout: words received %0d want 1000", m);
        end
    endtask

    initial begin
        reset = 1'b1; in_val = 1'b0; in_word = '0; out_rdy = 1'b0;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
